// File: rtl/mips_uart_pkg.sv
// Shared widths and FSM encodings for the UART-side blocks feeding the debug unit.
package mips_uart_pkg;

  localparam int NB_DATA        = 8;
  localparam int NB_WORD        = 32;
  localparam int BYTES_PER_WORD = NB_WORD / NB_DATA;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/tick_timeout_counter.sv
// Counts i_tick pulses since the last clear; o_expire is combinational on the terminal tick.
// A clear in the same cycle as the terminal tick suppresses the expiry.
module tick_timeout_counter #(
  parameter int TIMEOUT_TICKS = 1600,
  parameter int NB_TO         = $clog2(TIMEOUT_TICKS + 1)
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_expire
);

  logic [NB_TO-1:0] r_cnt;
  logic             w_terminal;

  assign w_terminal = (r_cnt == NB_TO'(TIMEOUT_TICKS - 1));
  assign o_expire   = i_tick & ~i_clear & w_terminal;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_expire) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_word_packer.sv
// Packs UART bytes MSB-first into words; word valid 1 cycle after the last byte, held until ready.
// Bytes arriving while a word is stalled are dropped and flagged; partial words expire on tick timeout.
module uart_word_packer
  import mips_uart_pkg::*;
#(
  parameter int NB_DATA       = mips_uart_pkg::NB_DATA,
  parameter int NB_WORD       = mips_uart_pkg::NB_WORD,
  parameter int TIMEOUT_TICKS = 1600,
  parameter int NB_TO         = $clog2(TIMEOUT_TICKS + 1)
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_flush,
  input  logic               i_word_ready,
  output logic [NB_WORD-1:0] o_word,
  output logic               o_word_valid,
  output logic [1:0]         o_byte_count,
  output logic               o_timeout,
  output logic               o_overrun
);

  localparam int L_BYTES = NB_WORD / NB_DATA;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NB_WORD-1:0] r_shift;
  logic [NB_WORD-1:0] w_shift_nxt;
  logic [NB_WORD-1:0] r_word;
  logic [1:0]         r_count;
  logic               r_valid;
  logic               r_timeout;
  logic               r_overrun;
  logic               w_capture;
  logic               w_load_word;
  logic               w_drop;
  logic               w_timeout;
  logic               w_expire;
  logic               w_to_clear;

  assign w_shift_nxt = {r_shift[NB_WORD-NB_DATA-1:0], i_rx_data};

  // The counter only runs while a partial word is held and no byte is arriving.
  assign w_to_clear = i_flush | i_rx_done | (r_state != ST_COLLECT);

  tick_timeout_counter #(
    .TIMEOUT_TICKS (TIMEOUT_TICKS),
    .NB_TO         (NB_TO)
  ) u_timeout (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (w_to_clear),
    .i_tick   (i_tick),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_load_word = 1'b0;
    w_drop      = 1'b0;
    w_timeout   = 1'b0;
    if (i_flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_rx_done) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (i_rx_done) begin
            w_capture = 1'b1;
            if (r_count == 2'(L_BYTES - 1)) begin
              w_load_word = 1'b1;
              w_state_nxt = ST_HOLD;
            end
          end else if (w_expire) begin
            w_timeout   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (i_word_ready) begin
            w_state_nxt = ST_IDLE;
            if (i_rx_done) begin
              w_capture   = 1'b1;
              w_state_nxt = ST_COLLECT;
            end
          end else if (i_rx_done) begin
            w_drop = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift   <= '0;
      r_word    <= '0;
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid   <= (w_state_nxt == ST_HOLD);
      r_timeout <= w_timeout;
      if (i_flush || w_timeout) begin
        r_shift <= '0;
      end else if (w_capture) begin
        r_shift <= w_shift_nxt;
      end
      if (i_flush || w_timeout || w_load_word) begin
        r_count <= '0;
      end else if (w_capture) begin
        r_count <= r_count + 1'b1;
      end
      // Only loaded on entry to HOLD, so the word is stable while valid.
      if (w_load_word) begin
        r_word <= w_shift_nxt;
      end
      if (i_flush) begin
        r_overrun <= 1'b0;
      end else if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_valid;
  assign o_byte_count = r_count;
  assign o_timeout    = r_timeout;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_word_packer.sv
// Scoreboard bench for uart_word_packer: expected words queued at stimulus, checked on handshake.
module tb_uart_word_packer;

  logic        clk;
  logic        i_rst_n;
  logic        i_tick;
  logic        i_rx_done;
  logic [7:0]  i_rx_data;
  logic        i_flush;
  logic        i_word_ready;
  logic [31:0] o_word;
  logic        o_word_valid;
  logic [1:0]  o_byte_count;
  logic        o_timeout;
  logic        o_overrun;

  int          n_vec;
  int          n_err;
  int          n_to;
  int          n_hs;
  logic [31:0] exp_q[$];

  uart_word_packer dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_tick       (i_tick),
    .i_rx_done    (i_rx_done),
    .i_rx_data    (i_rx_data),
    .i_flush      (i_flush),
    .i_word_ready (i_word_ready),
    .o_word       (o_word),
    .o_word_valid (o_word_valid),
    .o_byte_count (o_byte_count),
    .o_timeout    (o_timeout),
    .o_overrun    (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_done = 1'b1;
    i_rx_data = b;
    step();
    i_rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit push);
    if (push) exp_q.push_back(w);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
  endtask

  always @(negedge clk) begin
    if (o_timeout) n_to++;
    if (o_word_valid && i_word_ready) begin
      n_hs++;
      check_eq("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) check_eq("sb_word", o_word, exp_q.pop_front());
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_word"},  o_word, 32'd0);
    check_eq({tag, "_valid"}, {31'd0, o_word_valid}, 32'd0);
    check_eq({tag, "_count"}, {30'd0, o_byte_count}, 32'd0);
    check_eq({tag, "_to"},    {31'd0, o_timeout}, 32'd0);
    check_eq({tag, "_ovr"},   {31'd0, o_overrun}, 32'd0);
  endtask

  initial begin
    int to0;
    int hs0;
    logic [7:0] bytes1 [4];
    n_vec = 0; n_err = 0; n_to = 0; n_hs = 0;
    i_rst_n = 1'b0; i_tick = 1'b0; i_rx_done = 1'b0; i_rx_data = 8'h00;
    i_flush = 1'b0; i_word_ready = 1'b0;
    step(); step();
    check_all_zero("reset");
    i_rst_n = 1'b1;
    step();

    // Instruction word with ready held high: valid exactly one cycle.
    i_word_ready = 1'b1;
    bytes1[0] = 8'h20; bytes1[1] = 8'h01; bytes1[2] = 8'h00; bytes1[3] = 8'h0F;
    exp_q.push_back(32'h2001000F);
    for (int k = 0; k < 4; k++) begin
      send_byte(bytes1[k]);
      check_eq("t1_count", {30'd0, o_byte_count}, 32'((k + 1) % 4));
    end
    check_eq("t1_valid_hi", {31'd0, o_word_valid}, 32'd1);
    check_eq("t1_word", o_word, 32'h2001000F);
    step();
    check_eq("t1_valid_lo", {31'd0, o_word_valid}, 32'd0);

    // Stalled word must stay stable until ready.
    i_word_ready = 1'b0;
    hs0 = n_hs;
    send_word(32'hD5C455EE, 1'b1);
    for (int c = 0; c < 50; c++) begin
      check_eq("t2_hold_valid", {31'd0, o_word_valid}, 32'd1);
      check_eq("t2_hold_word", o_word, 32'hD5C455EE);
      step();
    end
    i_word_ready = 1'b1;
    step();
    check_eq("t2_valid_lo", {31'd0, o_word_valid}, 32'd0);
    check_eq("t2_count", {30'd0, o_byte_count}, 32'd0);
    step();
    check_eq("t2_one_hs", 32'(n_hs - hs0), 32'd1);

    // Partial word expires on the 1600th tick.
    to0 = n_to;
    send_byte(8'hAA);
    send_byte(8'hBB);
    for (int c = 0; c < 1600; c++) begin
      i_tick = 1'b1;
      step();
      if (c == 1598) check_eq("t3_no_early_to", 32'(n_to - to0), 32'd0);
    end
    i_tick = 1'b0;
    check_eq("t3_to_pulse", {31'd0, o_timeout}, 32'd1);
    check_eq("t3_count", {30'd0, o_byte_count}, 32'd0);
    step();
    check_eq("t3_to_once", {31'd0, o_timeout}, 32'd0);
    check_eq("t3_to_count", 32'(n_to - to0), 32'd1);
    send_word(32'h11223344, 1'b1);
    step();

    // A byte on the terminal tick wins over the timeout.
    to0 = n_to;
    send_byte(8'hAA);
    i_tick = 1'b1;
    for (int c = 0; c < 1599; c++) step();
    send_byte(8'hBB);
    i_tick = 1'b0;
    step();
    check_eq("t3r_no_to", 32'(n_to - to0), 32'd0);
    check_eq("t3r_count", {30'd0, o_byte_count}, 32'd2);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    check_eq("t3r_flush_count", {30'd0, o_byte_count}, 32'd0);

    // Overrun while stalled, sticky until flush.
    i_word_ready = 1'b0;
    send_word(32'h01020304, 1'b1);
    send_byte(8'h55);
    check_eq("t4_ovr", {31'd0, o_overrun}, 32'd1);
    step(); step();
    check_eq("t4_ovr_sticky", {31'd0, o_overrun}, 32'd1);
    check_eq("t4_word", o_word, 32'h01020304);
    i_word_ready = 1'b1;
    step();
    send_word(32'hA1B2C3D4, 1'b1);
    step();
    check_eq("t4_ovr_kept", {31'd0, o_overrun}, 32'd1);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    check_eq("t4_ovr_flushed", {31'd0, o_overrun}, 32'd0);

    // Flush coinciding with the 4th byte discards it.
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
    i_flush = 1'b1;
    send_byte(8'h40);
    i_flush = 1'b0;
    check_eq("t5_no_valid", {31'd0, o_word_valid}, 32'd0);
    check_eq("t5_count", {30'd0, o_byte_count}, 32'd0);
    step();
    check_eq("t5_still_no_valid", {31'd0, o_word_valid}, 32'd0);
    send_word(32'hDEADBEEF, 1'b1);
    step();

    // Asynchronous reset mid-COLLECT and mid-HOLD.
    send_byte(8'h99); send_byte(8'h88);
    #2 i_rst_n = 1'b0;
    #1 check_all_zero("t6_rst_collect");
    step();
    i_rst_n = 1'b1;
    step();
    i_word_ready = 1'b0;
    send_word(32'h77665544, 1'b0);
    check_eq("t6_hold_valid", {31'd0, o_word_valid}, 32'd1);
    #2 i_rst_n = 1'b0;
    #1 check_all_zero("t6_rst_hold");
    step();
    i_rst_n = 1'b1;
    i_word_ready = 1'b1;
    step();
    send_word(32'hCAFEF00D, 1'b1);
    step(); step();
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
